pe_array_engine: RTL and testbench
==================================

Name: pe_array_engine

Overview:
- Parametrised successor of the 8-PE vector SoC top.
- Holds a host-loaded operand memory: kernel rows at addresses 0..NUM_PE-1 and input vectors from VEC_BASE upward.
- Runs NUM_PE dot-product PEs in parallel over a run-time-selectable number of columns.
- Streams each result column out through a valid/ready handshake, replacing the fixed 32-column, free-running, no-backpressure behaviour.

Parameters:
- NUM_PE, 8, number of processing elements (result lanes)
- ELEMS, 16, elements per memory word / dot-product length
- DW, 32, signed element width
- ACC_W, 32, accumulator/result width per lane
- MEM_DEPTH, 64, operand memory words
- VEC_BASE, 32, address of vector column 0 (NUM_PE <= VEC_BASE < MEM_DEPTH)
- ADDR_W, $clog2(MEM_DEPTH), derived address width
- COL_W, $clog2(MEM_DEPTH-VEC_BASE+1), derived column-count width

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous active-low reset
- WE  in  1  host write enable
- InAddress  in  ADDR_W  host write address
- DataIn  in  ELEMS*DW  host write data
- num_cols  in  COL_W  columns to process; sampled with start
- start  in  1  run request, single-cycle pulse
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- cfg_err  out  1  one-cycle pulse: start rejected
- wr_err  out  1  one-cycle pulse: write ignored while busy
- res_valid  out  1  result column valid
- res_ready  in  1  consumer accepts result
- ResultAddress  out  COL_W  column index of current result
- FinalDataOut  out  NUM_PE*ACC_W  results; lane p at [(NUM_PE-p)*ACC_W-1 -: ACC_W]

Behaviour:
- Reset (async, RESET=0):
  - State IDLE.
  - All memory words zeroed.
  - busy, done, cfg_err, wr_err, res_valid all 0.
  - ResultAddress, FinalDataOut, accumulators and counters all 0.
- Memory writes: in IDLE, WE=1 writes DataIn to Mem[InAddress] at the clock edge. Addresses >= MEM_DEPTH are ignored. While busy, WE is ignored and wr_err pulses the next cycle.
- Operand mapping: PE p, column c, element e:
  - k = Mem[p][e*DW +: DW]
  - x = Mem[VEC_BASE+c][e*DW +: DW]
  - Both are signed.
- States: IDLE, COMPUTE, OUTPUT, DONE.
- IDLE, start=1:
  - num_cols==0 or num_cols > MEM_DEPTH-VEC_BASE: cfg_err pulses, stay IDLE.
  - Otherwise: latch num_cols, col=0, clear accumulators and elem_idx, go to COMPUTE, busy=1 from the next cycle.
- COMPUTE:
  - Each cycle every PE adds k[elem_idx]*x[elem_idx] to its accumulator; elem_idx increments.
  - The full 2*DW product is truncated to ACC_W; accumulation wraps two's-complement.
  - After the ELEMS-th MAC, register the accumulators into FinalDataOut, set ResultAddress=col and res_valid=1, go to OUTPUT.
  - res_valid therefore first rises ELEMS+1 cycles after the start edge.
- OUTPUT:
  - res_valid, FinalDataOut and ResultAddress hold stable until res_valid&&res_ready.
  - On acceptance, res_valid drops the next cycle.
  - If col == num_cols-1, go to DONE. Otherwise col++, clear accumulators and elem_idx, go to COMPUTE.
  - No result is ever dropped or overwritten.
- DONE: done=1 for exactly one cycle, busy=0 from the following cycle, return to IDLE. FinalDataOut holds the last value.
- start while busy is ignored (no cfg_err).
- Reset mid-run aborts immediately to reset values; no done pulse.
- Per-column latency is ELEMS+1 cycles plus consumer stall cycles. With res_ready tied high, the run length is num_cols*(ELEMS+1)+1 cycles to done.

Decomposition:
- Package pe_array_pkg holds:
  - state enum (IDLE, COMPUTE, OUTPUT, DONE)
  - default parameter constants
  - a function computing the lane slice offset
- Sub-module pe_mac (one instance per lane):
  - inputs: CLK, RESET, clr, en, signed a/b of width DW
  - output: acc of width ACC_W
  - one MAC per enabled cycle
  - generated NUM_PE times
- The controller FSM, the memory and the lane-to-word element mux live in pe_array_engine.

Test Plan:
1. Reset check: assert RESET=0 mid-COMPUTE → all outputs 0 asynchronously, no done. After release, readback is via a 1-column run with all-zero memory → every lane 0.
2. Single column, defaults: Mem[p] all elements = p+1, Mem[32] all elements = 2, num_cols=1, res_ready=1 → res_valid at cycle 17, lane p = 32*(p+1), ResultAddress=0, done at cycle 18.
3. Multi-column with backpressure: num_cols=3, Mem[32+c] elements = c+1, res_ready low for 5 cycles on column 1 → outputs held stable, columns 0,1,2 arrive in order, lane0 (k=1) = 16, 32, 48.
4. Signed/wrap: k element = -1 (0xFFFFFFFF), x = 0x7FFFFFFF, ELEMS=16 → lane = 16*(-0x7FFFFFFF) truncated to 32 bits = 0x00000010.
5. Config and write errors: num_cols=0 → cfg_err pulse, busy stays 0. num_cols=33 → cfg_err. WE during busy → wr_err pulse, memory unchanged, result unaffected.
6. Parametric build: NUM_PE=4, ELEMS=8, DW=16, ACC_W=40, MEM_DEPTH=16, VEC_BASE=8, num_cols=8 (max) → 8 results, ResultAddress 0..7, res_valid interval 9 cycles with res_ready=1.

Source files
------------

// File: rtl/pe_array_engine_pkg.sv
// pe_array_pkg: shared state encoding, default sizing and lane packing helper for the PE array engine
package pe_array_pkg;

  typedef enum logic [1:0] {IDLE, COMPUTE, OUTPUT, DONE} stateT;

  localparam int DEF_NUM_PE    = 8;
  localparam int DEF_ELEMS     = 16;
  localparam int DEF_DW        = 32;
  localparam int DEF_ACC_W     = 32;
  localparam int DEF_MEM_DEPTH = 64;
  localparam int DEF_VEC_BASE  = 32;

  // Lane 0 sits in the most significant slice of the packed result word
  function automatic int laneOffset(input int lane, input int numPe, input int accW);
    return (numPe - 1 - lane) * accW;
  endfunction

endpackage

// File: rtl/pe_array_engine_if.sv
// pe_array_engine_if: host write port, run control and result stream of the PE array engine
interface pe_array_engine_if import pe_array_pkg::*; #(
  parameter int NUM_PE    = DEF_NUM_PE,
  parameter int ELEMS     = DEF_ELEMS,
  parameter int DW        = DEF_DW,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int VEC_BASE  = DEF_VEC_BASE
);
  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int COL_W  = $clog2(MEM_DEPTH - VEC_BASE + 1);

  logic                    WE;
  logic [ADDR_W-1:0]       InAddress;
  logic [ELEMS*DW-1:0]     DataIn;
  logic [COL_W-1:0]        num_cols;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    cfg_err;
  logic                    wr_err;
  logic                    res_valid;
  logic                    res_ready;
  logic [COL_W-1:0]        ResultAddress;
  logic [NUM_PE*ACC_W-1:0] FinalDataOut;

  modport master (
    output WE, InAddress, DataIn, num_cols, start, res_ready,
    input  busy, done, cfg_err, wr_err, res_valid, ResultAddress, FinalDataOut
  );

  modport slave (
    input  WE, InAddress, DataIn, num_cols, start, res_ready,
    output busy, done, cfg_err, wr_err, res_valid, ResultAddress, FinalDataOut
  );

endinterface

// File: rtl/pe_array_engine_mac.sv
// pe_mac: one accumulating multiply lane, wrapping two's-complement at ACC_W bits
module pe_mac #(
  parameter int DW    = 32,
  parameter int ACC_W = 32
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic [ACC_W-1:0]     acc
);
  logic [ACC_W-1:0] prod;

  // Low ACC_W bits of the full product only depend on the low ACC_W bits of the sign-extended operands
  assign prod = ACC_W'(a) * ACC_W'(b);

  // Clear and accumulate may coincide: the first MAC of a new column starts from zero
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) acc <= '0;
    else if (clr || en) acc <= (clr ? '0 : acc) + (en ? prod : '0);

endmodule

// File: rtl/pe_array_engine.sv
// pe_array_engine: parallel dot-product PE array over a host-loaded operand memory with streamed results
module pe_array_engine import pe_array_pkg::*; #(
  parameter int NUM_PE    = DEF_NUM_PE,
  parameter int ELEMS     = DEF_ELEMS,
  parameter int DW        = DEF_DW,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int VEC_BASE  = DEF_VEC_BASE
) (
  input logic             CLK,
  input logic             RESET,
  pe_array_engine_if.slave bus
);
  localparam int ADDR_W = $clog2(MEM_DEPTH);
  localparam int COL_W  = $clog2(MEM_DEPTH - VEC_BASE + 1);
  localparam int EW     = $clog2(ELEMS + 1);

  logic [ELEMS*DW-1:0]     mem [MEM_DEPTH];
  stateT                   state;
  logic [COL_W-1:0]        col;
  logic [COL_W-1:0]        numColsQ;
  logic [COL_W-1:0]        colNext;
  logic [COL_W-1:0]        resultAddress;
  logic [EW-1:0]           elemIdx;
  logic [EW-1:0]           elemPick;
  logic                    busy;
  logic                    done;
  logic                    cfgErr;
  logic                    wrErr;
  logic                    resValid;
  logic [NUM_PE*ACC_W-1:0] finalDataOut;
  logic [NUM_PE*ACC_W-1:0] accFlat;
  logic [ADDR_W-1:0]       vecAddr;
  logic [ELEMS*DW-1:0]     vecWord;
  logic signed [DW-1:0]    xSel;
  logic                    startOk;
  logic                    accept;
  logic                    lastCol;
  logic                    macEn;
  logic                    macClr;

  assign startOk = bus.num_cols != '0 && int'(bus.num_cols) <= MEM_DEPTH - VEC_BASE;
  assign accept  = state == OUTPUT && resValid && bus.res_ready;
  assign lastCol = col == numColsQ - COL_W'(1);

  // The acceptance cycle already performs the first MAC of the following column
  assign colNext  = (state == OUTPUT && !lastCol) ? col + COL_W'(1) : col;
  assign vecAddr  = ADDR_W'(VEC_BASE) + ADDR_W'(colNext);
  assign vecWord  = mem[vecAddr];
  assign elemPick = elemIdx < EW'(ELEMS) ? elemIdx : '0;
  assign xSel     = vecWord[elemPick*DW +: DW];

  assign macEn  = (state == COMPUTE && elemIdx < EW'(ELEMS)) || (accept && !lastCol);
  assign macClr = (state == IDLE && bus.start && startOk) || accept;

  for (genvar g = 0; g < NUM_PE; g++) begin : gLane
    logic [ACC_W-1:0] acc;
    pe_mac #(.DW(DW), .ACC_W(ACC_W)) uMac (
      .CLK  (CLK),
      .RESET(RESET),
      .clr  (macClr),
      .en   (macEn),
      .a    (mem[g][elemPick*DW +: DW]),
      .b    (xSel),
      .acc  (acc)
    );
    assign accFlat[laneOffset(g, NUM_PE, ACC_W) +: ACC_W] = acc;
  end

  // Operand memory: host writes land only while idle and inside the array
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= '0;
    else if (bus.WE && state == IDLE && int'(bus.InAddress) < MEM_DEPTH) mem[bus.InAddress] <= bus.DataIn;

  // Run controller: sequences MAC columns, holds each result until the consumer takes it
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state         <= IDLE;
      col           <= '0;
      numColsQ      <= '0;
      elemIdx       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfgErr        <= 1'b0;
      wrErr         <= 1'b0;
      resValid      <= 1'b0;
      resultAddress <= '0;
      finalDataOut  <= '0;
    end else begin
      done   <= 1'b0;
      cfgErr <= 1'b0;
      wrErr  <= bus.WE && busy;
      case (state)
        IDLE:
          if (bus.start && !startOk) cfgErr <= 1'b1;
          else if (bus.start) begin
            numColsQ <= bus.num_cols;
            col      <= '0;
            elemIdx  <= '0;
            busy     <= 1'b1;
            state    <= COMPUTE;
          end
        COMPUTE:
          if (elemIdx == EW'(ELEMS)) begin
            finalDataOut  <= accFlat;
            resultAddress <= col;
            resValid      <= 1'b1;
            elemIdx       <= '0;
            state         <= OUTPUT;
          end else elemIdx <= elemIdx + EW'(1);
        OUTPUT:
          if (bus.res_ready) begin
            resValid <= 1'b0;
            if (lastCol) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              col     <= col + COL_W'(1);
              elemIdx <= EW'(1);
              state   <= COMPUTE;
            end
          end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end

  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.cfg_err       = cfgErr;
  assign bus.wr_err        = wrErr;
  assign bus.res_valid     = resValid;
  assign bus.ResultAddress = resultAddress;
  assign bus.FinalDataOut  = finalDataOut;

endmodule

// File: tb/tb_pe_array_engine.sv
// tb_pe_array_engine: directed checks of the default engine and of a small parametric build
module tb_pe_array_engine;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pe_array_engine_if busA ();
  pe_array_engine_if #(.NUM_PE(4), .ELEMS(8), .DW(16), .ACC_W(40), .MEM_DEPTH(16), .VEC_BASE(8)) busB ();

  pe_array_engine dutA (.CLK(CLK), .RESET(RESET), .bus(busA));
  pe_array_engine #(.NUM_PE(4), .ELEMS(8), .DW(16), .ACC_W(40), .MEM_DEPTH(16), .VEC_BASE(8))
    dutB (.CLK(CLK), .RESET(RESET), .bus(busB));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] fillA(input logic [31:0] v);
    logic [511:0] r;
    for (int e = 0; e < 16; e++) r[e*32 +: 32] = v;
    return r;
  endfunction

  function automatic logic [127:0] fillB(input logic [15:0] v);
    logic [127:0] r;
    for (int e = 0; e < 8; e++) r[e*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [31:0] laneA(input int p);
    return busA.FinalDataOut[(8-p)*32-1 -: 32];
  endfunction

  function automatic logic [39:0] laneB(input int p);
    return busB.FinalDataOut[(4-p)*40-1 -: 40];
  endfunction

  task automatic writeA(input int addr, input logic [511:0] data);
    busA.WE = 1'b1;
    busA.InAddress = 6'(addr);
    busA.DataIn = data;
    tick();
    busA.WE = 1'b0;
  endtask

  task automatic writeB(input int addr, input logic [127:0] data);
    busB.WE = 1'b1;
    busB.InAddress = 4'(addr);
    busB.DataIn = data;
    tick();
    busB.WE = 1'b0;
  endtask

  task automatic startA(input int cols);
    busA.num_cols = 6'(cols);
    busA.start = 1'b1;
    tick();
    busA.start = 1'b0;
  endtask

  task automatic waitValidA(input string tag);
    int n = 0;
    while (!busA.res_valid && n < 100) begin
      tick();
      n++;
    end
    check(tag, busA.res_valid, 1);
  endtask

  initial begin
    int n;
    logic sawDone;
    logic [39:0] e40;
    busA.WE = 0; busA.InAddress = 0; busA.DataIn = 0; busA.num_cols = 0; busA.start = 0; busA.res_ready = 0;
    busB.WE = 0; busB.InAddress = 0; busB.DataIn = 0; busB.num_cols = 0; busB.start = 0; busB.res_ready = 0;
    repeat (3) tick();
    check("rst_busy", busA.busy, 0);
    check("rst_done", busA.done, 0);
    check("rst_cfg_err", busA.cfg_err, 0);
    check("rst_wr_err", busA.wr_err, 0);
    check("rst_valid", busA.res_valid, 0);
    check("rst_addr", busA.ResultAddress, 0);
    check("rst_data", busA.FinalDataOut, 0);
    check("rst_b_valid", busB.res_valid, 0);
    check("rst_b_data", busB.FinalDataOut, 0);
    RESET = 1'b1;
    tick();

    for (int p = 0; p < 8; p++) writeA(p, fillA(32'(p + 1)));
    writeA(32, fillA(2));
    busA.res_ready = 1'b1;
    startA(1);
    check("single_busy", busA.busy, 1);
    repeat (16) tick();
    check("single_valid_c16", busA.res_valid, 0);
    tick();
    check("single_valid_c17", busA.res_valid, 1);
    check("single_addr", busA.ResultAddress, 0);
    for (int p = 0; p < 8; p++) check($sformatf("single_lane%0d", p), laneA(p), 32 * (p + 1));
    tick();
    check("single_done_c18", busA.done, 1);
    check("single_valid_drop", busA.res_valid, 0);
    tick();
    check("single_done_pulse", busA.done, 0);
    check("single_busy_clear", busA.busy, 0);
    check("single_hold", laneA(3), 128);

    for (int c = 0; c < 3; c++) writeA(32 + c, fillA(32'(c + 1)));
    busA.res_ready = 1'b0;
    startA(3);
    waitValidA("multi_wait0");
    check("multi_addr0", busA.ResultAddress, 0);
    check("multi_c0_lane0", laneA(0), 16);
    check("multi_c0_lane7", laneA(7), 128);
    busA.res_ready = 1'b1;
    tick();
    busA.res_ready = 1'b0;
    waitValidA("multi_wait1");
    check("multi_addr1", busA.ResultAddress, 1);
    check("multi_c1_lane0", laneA(0), 32);
    busA.WE = 1'b1;
    busA.InAddress = 0;
    busA.DataIn = fillA(100);
    tick();
    busA.WE = 1'b0;
    check("busy_wr_err", busA.wr_err, 1);
    busA.start = 1'b1;
    busA.num_cols = 0;
    tick();
    busA.start = 1'b0;
    busA.num_cols = 3;
    check("busy_wr_err_pulse", busA.wr_err, 0);
    check("busy_start_no_cfg_err", busA.cfg_err, 0);
    repeat (3) tick();
    check("stall_valid", busA.res_valid, 1);
    check("stall_addr", busA.ResultAddress, 1);
    check("stall_c1_lane0", laneA(0), 32);
    check("stall_c1_lane5", laneA(5), 192);
    busA.res_ready = 1'b1;
    tick();
    busA.res_ready = 1'b0;
    check("multi_valid_drop", busA.res_valid, 0);
    waitValidA("multi_wait2");
    check("multi_addr2", busA.ResultAddress, 2);
    check("multi_c2_lane0", laneA(0), 48);
    check("multi_c2_lane7", laneA(7), 384);
    busA.res_ready = 1'b1;
    tick();
    check("multi_done", busA.done, 1);
    tick();
    check("multi_idle", busA.busy, 0);

    writeA(0, fillA(32'hFFFF_FFFF));
    writeA(32, fillA(32'h7FFF_FFFF));
    startA(1);
    waitValidA("wrap_wait");
    check("wrap_lane0", laneA(0), 32'h0000_0010);
    check("wrap_lane1", laneA(1), 32'hFFFF_FFE0);
    check("wrap_lane3", laneA(3), 32'hFFFF_FFC0);
    repeat (2) tick();

    startA(1);
    repeat (5) tick();
    check("abort_pre_busy", busA.busy, 1);
    RESET = 1'b0;
    #1;
    check("abort_busy", busA.busy, 0);
    check("abort_valid", busA.res_valid, 0);
    check("abort_data", busA.FinalDataOut, 0);
    sawDone = 1'b0;
    repeat (20) begin
      tick();
      sawDone |= busA.done;
    end
    RESET = 1'b1;
    repeat (20) begin
      tick();
      sawDone |= busA.done;
    end
    check("abort_no_done", sawDone, 0);
    startA(1);
    waitValidA("readback_wait");
    check("readback_data", busA.FinalDataOut, 0);
    check("readback_addr", busA.ResultAddress, 0);
    tick();
    check("readback_done", busA.done, 1);
    tick();

    startA(0);
    check("cfg0_err", busA.cfg_err, 1);
    check("cfg0_busy", busA.busy, 0);
    tick();
    check("cfg0_pulse", busA.cfg_err, 0);
    check("cfg0_still_idle", busA.busy, 0);
    startA(33);
    check("cfg33_err", busA.cfg_err, 1);
    check("cfg33_busy", busA.busy, 0);
    tick();
    startA(32);
    check("cfg32_no_err", busA.cfg_err, 0);
    check("cfg32_busy", busA.busy, 1);
    n = 0;
    while (!busA.done && n < 1000) begin
      tick();
      n++;
    end
    check("cfg32_run_len", n, 545);
    check("cfg32_last_addr", busA.ResultAddress, 31);
    tick();
    check("cfg32_idle", busA.busy, 0);

    for (int p = 0; p < 3; p++) writeB(p, fillB(16'(p + 1)));
    writeB(3, fillB(16'hFFFF));
    for (int c = 0; c < 8; c++) writeB(8 + c, fillB(16'(c + 1)));
    busB.num_cols = 9;
    busB.start = 1'b1;
    tick();
    busB.start = 1'b0;
    check("param_cfg9_err", busB.cfg_err, 1);
    busB.res_ready = 1'b1;
    busB.num_cols = 8;
    busB.start = 1'b1;
    tick();
    busB.start = 1'b0;
    check("param_busy", busB.busy, 1);
    for (int c = 0; c < 8; c++) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (!busB.res_valid && n < 50);
      e40 = 40'(-8 * (c + 1));
      check($sformatf("param_interval%0d", c), n, 9);
      check($sformatf("param_addr%0d", c), busB.ResultAddress, c);
      check($sformatf("param_c%0d_lane0", c), laneB(0), 8 * (c + 1));
      check($sformatf("param_c%0d_lane2", c), laneB(2), 24 * (c + 1));
      check($sformatf("param_c%0d_lane3", c), laneB(3), e40);
    end
    tick();
    check("param_done", busB.done, 1);
    tick();
    check("param_idle", busB.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
